// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: transmit FSM states, flag/abort octets and the FCS-16 polynomial.
package hdlc_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StSflag = 3'd1,
        StData  = 3'd2,
        StFcs   = 3'd3,
        StEflag = 3'd4,
        StGap   = 3'd5,
        StAbort = 3'd6
    } tx_state_t;

    localparam logic [7:0]  HDLC_FLAG  = 8'h7E;
    localparam logic [7:0]  HDLC_ABORT = 8'hFE;
    localparam logic [15:0] FCS_POLY   = 16'h8005;
    localparam logic [15:0] FCS_INIT   = 16'h0000;
    localparam int unsigned FCS_BITS   = 16;

    // One serial CRC step: the incoming bit is compared against the register MSB.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? FCS_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/hdlc_tx_framer_if.sv
// Transmit-buffer handshake and serial line bundle between the buffer side and the framer.
interface hdlc_tx_framer_if;

    logic       Tx_Enable;
    logic       Tx_DataAvail;
    logic [7:0] Tx_DataIn;
    logic       Tx_FCSen;
    logic       Tx_AbortFrame;
    logic       Tx_RdBuff;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;

    modport master (
        output Tx_Enable, Tx_DataAvail, Tx_DataIn, Tx_FCSen, Tx_AbortFrame,
        input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
    );

    modport slave (
        input  Tx_Enable, Tx_DataAvail, Tx_DataIn, Tx_FCSen, Tx_AbortFrame,
        output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
    );

endinterface

// File: rtl/hdlc_crc16.sv
// Serial CRC-16 (x^16+x^15+x^2+1), one bit per enabled cycle; reused by the receive checker.
module hdlc_crc16
    import hdlc_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                din,
    output logic [FCS_BITS-1:0] rem
);

    logic [FCS_BITS-1:0] rem_q, rem_d;

    // Clear has priority so a new frame always starts from the initial value.
    always_comb begin
        rem_d = rem_q;
        if (clr) begin
            rem_d = FCS_INIT;
        end else if (en) begin
            rem_d = crc16_step(rem_q, din);
        end
    end

    // Remainder register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= FCS_INIT;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign rem = rem_q;

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: start flag, zero-stuffed payload and FCS, closing flag, abort and gap.
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int unsigned IDLE_GAP   = 8,
    parameter int unsigned ONES_LIMIT = 5
) (
    input  logic            Clk,
    input  logic            Rst,
    hdlc_tx_framer_if.slave bus
);

    localparam int unsigned OnesW = $clog2(ONES_LIMIT + 1);
    localparam int unsigned GapW  = $clog2(IDLE_GAP + 1);
    localparam logic [OnesW-1:0] OnesMax = OnesW'(ONES_LIMIT);
    localparam logic [GapW-1:0]  GapFull = GapW'(IDLE_GAP);
    localparam logic [GapW-1:0]  GapLast = GapW'(IDLE_GAP - 1);

    tx_state_t          state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [OnesW-1:0]   ones_cnt_q, ones_cnt_d;
    logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               fcs_en_q, fcs_en_d;
    // A payload that ends on a ones run still owes a stuffed zero before the closing flag.
    logic               tail_q, tail_d;
    logic               done_q, done_d;

    logic [FCS_BITS-1:0] crc_rem;
    logic               crc_clr, crc_en;
    logic               in_frame, abort_req, stuff, start_req, rd_buff, tx_bit;
    logic [OnesW-1:0]   ones_inc;

    hdlc_crc16 u_crc (
        .clk   (Clk),
        .rst_n (Rst),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (shift_q[0]),
        .rem   (crc_rem)
    );

    // Line bit, fetch strobe and the per-cycle control decodes.
    always_comb begin
        in_frame  = state_q inside {StSflag, StData, StFcs, StEflag};
        abort_req = bus.Tx_AbortFrame && in_frame;
        stuff     = (state_q == StData || state_q == StFcs) && (ones_cnt_q == OnesMax);
        start_req = bus.Tx_Enable &&
                    ((state_q == StIdle && gap_cnt_q == GapFull) ||
                     (state_q == StGap && gap_cnt_q == GapLast));
        rd_buff   = bus.Tx_DataAvail && !abort_req && (bit_cnt_q == 4'd7) &&
                    (state_q == StSflag || (state_q == StData && !stuff));
        case (state_q)
            StSflag, StEflag: tx_bit = HDLC_FLAG[bit_cnt_q[2:0]];
            StAbort:          tx_bit = HDLC_ABORT[bit_cnt_q[2:0]];
            StData:           tx_bit = !stuff && shift_q[0];
            StFcs:            tx_bit = !stuff && crc_rem[bit_cnt_q];
            default:          tx_bit = 1'b1;
        endcase
        ones_inc = tx_bit ? ones_cnt_q + 1'b1 : '0;
    end

    // Next-state logic; abort is applied last so it overrides any in-frame decision.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ones_cnt_d = ones_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        shift_d    = shift_q;
        fcs_en_d   = fcs_en_q;
        tail_d     = tail_q;
        done_d     = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;

        case (state_q)
            StSflag: begin
                bit_cnt_d  = bit_cnt_q + 4'd1;
                ones_cnt_d = '0;
                if (bit_cnt_q == 4'd7) begin
                    bit_cnt_d = '0;
                    if (rd_buff) begin
                        state_d = StData;
                        shift_d = bus.Tx_DataIn;
                    end else if (fcs_en_q) begin
                        state_d = StFcs;
                    end else begin
                        state_d = StEflag;
                    end
                end
            end
            StData: begin
                if (stuff) begin
                    ones_cnt_d = '0;
                    if (tail_q) begin
                        state_d   = StEflag;
                        bit_cnt_d = '0;
                        tail_d    = 1'b0;
                    end
                end else begin
                    crc_en     = 1'b1;
                    ones_cnt_d = ones_inc;
                    shift_d    = {1'b0, shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        if (rd_buff) begin
                            shift_d   = bus.Tx_DataIn;
                            bit_cnt_d = '0;
                        end else if (fcs_en_q) begin
                            state_d   = StFcs;
                            bit_cnt_d = '0;
                        end else if (ones_inc == OnesMax) begin
                            tail_d = 1'b1;
                        end else begin
                            state_d   = StEflag;
                            bit_cnt_d = '0;
                        end
                    end
                end
            end
            StFcs: begin
                if (stuff) begin
                    ones_cnt_d = '0;
                    if (tail_q) begin
                        state_d   = StEflag;
                        bit_cnt_d = '0;
                        tail_d    = 1'b0;
                    end
                end else begin
                    ones_cnt_d = ones_inc;
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        if (ones_inc == OnesMax) begin
                            tail_d = 1'b1;
                        end else begin
                            state_d   = StEflag;
                            bit_cnt_d = '0;
                        end
                    end
                end
            end
            StEflag: begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    state_d   = StGap;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    done_d    = 1'b1;
                end
            end
            StAbort: begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd7) begin
                    state_d   = StGap;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GapLast) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_req) begin
            state_d    = StSflag;
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
            tail_d     = 1'b0;
            fcs_en_d   = bus.Tx_FCSen;
            crc_clr    = 1'b1;
        end

        if (abort_req) begin
            state_d    = StAbort;
            bit_cnt_d  = '0;
            ones_cnt_d = '0;
            tail_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    // State registers; the gap counter resets full so the first frame starts at once.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            ones_cnt_q <= '0;
            gap_cnt_q  <= GapFull;
            shift_q    <= '0;
            fcs_en_q   <= 1'b0;
            tail_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_cnt_q <= ones_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            shift_q    <= shift_d;
            fcs_en_q   <= fcs_en_d;
            tail_q     <= tail_d;
            done_q     <= done_d;
        end
    end

    assign bus.Tx              = tx_bit;
    assign bus.Tx_RdBuff       = rd_buff;
    assign bus.Tx_ValidFrame   = in_frame;
    assign bus.Tx_Done         = done_q;
    assign bus.Tx_AbortedTrans = (state_q == StAbort) && (bit_cnt_q == 4'd0);

endmodule
